// File: rtl/up_down_counter.sv
// Modular binary up/down counter with parallel load, one-cycle wrap pulse
// and combinational terminal-value flags.
module up_down_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mod,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

  // Load beats count enable; a load never produces a wrap pulse.
  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (load) begin
      next_count = load_val;
    end else if (en) begin
      if (mod) begin
        next_count = count + ONE;
        next_wrap  = (count == ALL_ONES);
      end else begin
        next_count = count - ONE;
        next_wrap  = (count == ZERO);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= next_count;
      wrap  <= next_wrap;
    end
  end

  assign at_max  = (count == ALL_ONES);
  assign at_zero = (count == ZERO);

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench: directed test-plan sequences with literal expectations,
// then randomized traffic checked each cycle against an arithmetic model.
module tb_up_down_counter;

  localparam int W   = 3;
  localparam int MOD = 1 << W;

  logic         clk_tb;
  logic         rst;
  logic         en;
  logic         mod;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         wrap;
  logic         at_max;
  logic         at_zero;

  int checks   = 0;
  int failures = 0;

  int model_count = 0;
  int model_wrap  = 0;

  up_down_counter #(.WIDTH(W)) dut (
    .clk      (clk_tb),
    .rst      (rst),
    .en       (en),
    .mod      (mod),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .wrap     (wrap),
    .at_max   (at_max),
    .at_zero  (at_zero)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: plain modular arithmetic on integers.
  always @(posedge clk_tb or negedge rst) begin
    if (!rst) begin
      model_count = 0;
      model_wrap  = 0;
    end else if (load) begin
      model_count = int'(load_val);
      model_wrap  = 0;
    end else if (en) begin
      if (mod) begin
        model_wrap  = (model_count == MOD - 1) ? 1 : 0;
        model_count = (model_count + 1) % MOD;
      end else begin
        model_wrap  = (model_count == 0) ? 1 : 0;
        model_count = (model_count + MOD - 1) % MOD;
      end
    end else begin
      model_wrap = 0;
    end
  end

  always @(negedge clk_tb) begin
    check("model_count", int'(count), model_count);
    check("model_wrap", int'(wrap), model_wrap);
    check("model_at_max", int'(at_max), (model_count == MOD - 1) ? 1 : 0);
    check("model_at_zero", int'(at_zero), (model_count == 0) ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic expect_state(input string name, input int c, input int w);
    check({name, "_count"}, int'(count), c);
    check({name, "_wrap"}, int'(wrap), w);
    check({name, "_at_max"}, int'(at_max), (c == MOD - 1) ? 1 : 0);
    check({name, "_at_zero"}, int'(at_zero), (c == 0) ? 1 : 0);
  endtask

  int up_seq[10]  = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
  int dn_seq[5]   = '{1, 0, 7, 6, 5};

  initial begin
    rst = 1'b0; en = 1'b0; mod = 1'b0; load = 1'b0; load_val = '0;
    repeat (2) @(negedge clk_tb);
    #1;
    expect_state("reset_hold", 0, 0);

    rst = 1'b1;
    tick();
    expect_state("release_idle", 0, 0);

    en = 1'b1; mod = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_state("count_up", up_seq[i], (i == 7) ? 1 : 0);
    end

    mod = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_state("count_down", dn_seq[i], (i == 2) ? 1 : 0);
    end

    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state("hold", 5, 0);
    end

    load = 1'b1; load_val = 3'd7;
    tick();
    expect_state("load7", 7, 0);
    load = 1'b0; en = 1'b1; mod = 1'b1;
    tick();
    expect_state("rev_up_wrap", 0, 1);
    mod = 1'b0;
    tick();
    expect_state("rev_down_wrap", 7, 1);

    load = 1'b1; load_val = 3'd6; en = 1'b1; mod = 1'b1;
    tick();
    expect_state("load_priority", 6, 0);
    load_val = 3'd7;
    tick();
    load_val = 3'd0; mod = 1'b0;
    tick();
    expect_state("load_zero_from_max", 0, 0);

    load_val = 3'd3;
    tick();
    load = 1'b0; en = 1'b1; mod = 1'b1;
    tick();
    expect_state("pre_async", 4, 0);
    #2 rst = 1'b0;
    #1;
    expect_state("async_reset", 0, 0);
    @(negedge clk_tb);
    @(negedge clk_tb);
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_state("resume", i, 0);
    end

    for (int n = 0; n < 600; n++) begin
      @(negedge clk_tb);
      #1;
      en       = ($urandom_range(0, 3) != 0);
      mod      = $urandom_range(0, 1) == 1;
      load     = ($urandom_range(0, 7) == 0);
      load_val = W'($urandom_range(0, MOD - 1));
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b0;
        #1;
        check("rand_async_reset", int'(count), 0);
        @(negedge clk_tb);
        #1 rst = 1'b1;
      end
    end

    @(negedge clk_tb);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
